fir_mac_sequencer: RTL and testbench
====================================

# fir_mac_sequencer

Sequencer that drives one shared multiply-accumulate unit as an NTAPS-tap FIR filter. It accepts input samples over a valid/ready handshake and keeps them in a tap delay line, next to a writable coefficient bank. For each sample it clears the MAC and streams one (sample, coefficient) pair per cycle into it. It then captures the accumulated result and presents it as a one-cycle output strobe. It sits upstream of the MAC (drives `inputa`/`inputb`/`en`/`clr`) and downstream of it (reads `final_result`).

## Interface
- `NTAPS`, 8: number of taps; power of two, 2..16.
- `A_W`, 25: sample width; unsigned, matches MAC `inputa`.
- `B_W`, 10: coefficient width; two's complement, matches MAC `inputb`.
- `clk` input 1: single clock; all logic rising-edge.
- `clr` input 1: asynchronous, active-high reset.
- `coef_we` input 1: coefficient write strobe.
- `coef_addr` input log2(NTAPS): coefficient index.
- `coef_wdata` input B_W: coefficient value.
- `s_valid` input 1: input sample valid.
- `s_ready` output 1: block can accept a sample.
- `s_data` input A_W: input sample.
- `mac_a` output A_W: to MAC `inputa`.
- `mac_b` output B_W: to MAC `inputb`.
- `mac_en` output 1: to MAC `en`.
- `mac_clr` output 1: to MAC `clr` (synchronous clear in the MAC).
- `mac_result` input 25: from MAC `final_result`.
- `y_valid` output 1: one-cycle output strobe.
- `y_data` output 25: filter output, held between strobes.
- `busy` output 1: a sample is in process.

## Operation
- Storage:
  - Delay line `x[0..NTAPS-1]`, each A_W bits.
  - Coefficient bank `c[0..NTAPS-1]`, each B_W bits.
  - All entries reset to 0.
- Sample accept:
  - A sample is taken on an edge where `s_valid && s_ready`.
  - On that edge: `x[0] <= s_data` and `x[k] <= x[k-1]`.
  - `s_ready` = 1 only in IDLE.
- FSM states: IDLE, CLEAR, RUN, DRAIN, DONE.
  - IDLE → CLEAR on accept.
  - CLEAR → RUN after 1 cycle. `mac_clr` = 1.
  - RUN lasts NTAPS cycles with tap counter t = 0..NTAPS-1. `mac_en` = 1, `mac_a` = x[t], `mac_b` = c[t].
  - RUN → DRAIN when t = NTAPS-1.
  - DRAIN lasts 1 cycle. `mac_result` is final during it; `y_data <= mac_result` on the edge leaving DRAIN.
  - DONE lasts 1 cycle with `y_valid` = 1, then → IDLE.
- Outputs are decoded from the state and counter flops only; no path from inputs to outputs.
  - Outside RUN: `mac_en` = 0, `mac_a` = 0, `mac_b` = 0.
  - `mac_clr` = 1 in CLEAR or while `clr` is high, so the MAC also clears on the first edge after reset.
- `busy` = 1 in every state except IDLE.
- Coefficient writes:
  - Take effect on the edge when `coef_we` = 1 and `busy` = 0.
  - Ignored while busy, so the coefficient set is stable for a whole sample.
- MAC arithmetic the bench model must reproduce, per tap:
  - p = (x × |c|) >> 9, truncating.
  - Accumulator += p if c ≥ 0, else −= p.
  - Result is modulo 2^25.
  - c = −512 gives |c| = 512.

## Timing
- Accept edge at E0; CLEAR in cycle 1; RUN in cycles 2..NTAPS+1; DRAIN in cycle NTAPS+2; `y_valid` high in cycle NTAPS+3; `s_ready` high again in cycle NTAPS+4.
- Latency from the accept edge to `y_valid`: NTAPS+3 cycles.
- Throughput: 1 sample per NTAPS+4 cycles.
- `s_valid` held while busy: the sample is not consumed and `s_data` must stay stable until accepted. The upstream may drop `s_valid` without penalty.
- A coefficient write and an accept on the same IDLE edge: the write completes, and the new value is used for that sample.
- Reset values, including asynchronous `clr` mid-operation:
  - State goes to IDLE immediately.
  - Delay line, coefficients and `y_data` = 0.
  - `y_valid` = 0, `busy` = 0, `mac_en` = 0, `mac_a` = 0, `mac_b` = 0, `mac_clr` = 1.
  - `s_ready` = 0 while `clr` is high and 1 after release.
  - No `y_valid` for the aborted sample.

## Test plan
- Impulse response:
  - Stimulus: c = {256, 128, 64, 0, 0, 0, 0, 0}; feed 1024, then seven 0s.
  - Response: `y_data` = 512, 256, 128, then 0; each `y_valid` exactly 11 cycles after its accept edge.
- Negative coefficient:
  - Stimulus: c[0] = −256 (10'h300), all other c = 0; feed 1024.
  - Response: `y_data` = 25'h1FFFE00.
- Truncation and wrap:
  - Stimulus 1: c[0] = 511, x = 1. Response: `y_data` = 0.
  - Stimulus 2: all c = 511, feed 25'h1FFFFFF eight times. Response: `y_data` after the 8th sample matches the mod-2^25 model.
- Backpressure:
  - Stimulus: `s_valid` held high with changing data, timed to each accept edge.
  - Response: exactly one accept per 12 cycles; `s_ready` low while `busy`; no sample lost or duplicated.
- Write while busy:
  - Stimulus: `coef_we` with c[0] = 100 during RUN.
  - Response: write ignored, output uses the old c[0]; the same write in IDLE does take effect.
- Reset mid-RUN:
  - Stimulus: assert `clr` in RUN cycle 3.
  - Response: outputs go to reset values with no clock edge needed, no `y_valid`, and a next sample of 1024 with c[0] = 256 yields 512.

Source files
------------

// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: runs one external MAC as an NTAPS-tap FIR over a sample delay line.
// Latency: y_valid NTAPS+3 cycles after the accept edge; throughput 1 sample / NTAPS+4 cycles.
// Backpressure: s_ready only in IDLE, so a held s_valid waits until the previous sample is done.
//
// Ports:
//   clk, clr                 clock, async active-high reset
//   coef_we/addr/wdata       coefficient bank write (ignored while busy)
//   s_valid/s_ready/s_data   sample input handshake
//   mac_a/mac_b/mac_en/mac_clr  operands and controls to the shared MAC
//   mac_result               accumulated MAC result
//   y_valid/y_data           one-cycle output strobe, y_data held between strobes
//   busy                     a sample is in process
module fir_mac_sequencer #(
  parameter int NTAPS = 8,
  parameter int A_W   = 25,
  parameter int B_W   = 10,
  localparam int TW   = $clog2(NTAPS)
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           coef_we,
  input  logic [TW-1:0]  coef_addr,
  input  logic [B_W-1:0] coef_wdata,
  input  logic           s_valid,
  output logic           s_ready,
  input  logic [A_W-1:0] s_data,
  output logic [A_W-1:0] mac_a,
  output logic [B_W-1:0] mac_b,
  output logic           mac_en,
  output logic           mac_clr,
  input  logic [24:0]    mac_result,
  output logic           y_valid,
  output logic [24:0]    y_data,
  output logic           busy
);

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_t;

  state_t         state, state_nx;
  logic [TW-1:0]  tap, tap_nx;
  logic [A_W-1:0] x [NTAPS];
  logic [B_W-1:0] c [NTAPS];
  logic           accept;
  logic           last_tap;

  assign accept   = s_valid && s_ready;
  assign last_tap = (tap == TW'(NTAPS - 1));

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= IDLE;
      tap   <= '0;
    end else begin
      state <= state_nx;
      tap   <= tap_nx;
    end
  end

  // Tap counter only advances inside RUN; it is zero in every other state.
  always_comb begin
    state_nx = state;
    tap_nx   = '0;
    case (state)
      IDLE:    if (accept) state_nx = CLEAR;
      CLEAR:   state_nx = RUN;
      RUN: begin
        if (last_tap) state_nx = DRAIN;
        else          tap_nx   = tap + 1'b1;
      end
      DRAIN:   state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs come from state/tap flops only. clr is the exception: it forces
  // mac_clr so the MAC is cleared on the first edge after reset, and holds
  // s_ready low while the block is in reset.
  always_comb begin
    busy    = (state != IDLE);
    s_ready = (state == IDLE) && !clr;
    y_valid = (state == DONE);
    mac_clr = clr || (state == CLEAR);
    mac_en  = 1'b0;
    mac_a   = '0;
    mac_b   = '0;
    if (state == RUN) begin
      mac_en = 1'b1;
      mac_a  = x[tap];
      mac_b  = c[tap];
    end
  end

  // Delay line shifts on accept; coefficient writes are blocked while busy so
  // one sample always sees a stable coefficient set. A write on the accept
  // edge lands before RUN and is therefore used by that sample.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int k = 0; k < NTAPS; k++) begin
        x[k] <= '0;
        c[k] <= '0;
      end
    end else begin
      if (accept) begin
        x[0] <= s_data;
        for (int k = 1; k < NTAPS; k++) begin
          x[k] <= x[k-1];
        end
      end
      if (coef_we && !busy) begin
        c[coef_addr] <= coef_wdata;
      end
    end
  end

  // The last product lands in the MAC on the edge entering DRAIN, so
  // mac_result is final throughout DRAIN.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      y_data <= '0;
    end else if (state == DRAIN) begin
      y_data <= mac_result;
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb_fir_mac_sequencer: directed stimulus with a queue-based scoreboard for fir_mac_sequencer.
// A behavioural MAC stands in for the external unit; outputs are checked on the falling edge.
module tb_fir_mac_sequencer;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        coef_we = 1'b0;
  logic [2:0]  coef_addr = '0;
  logic [9:0]  coef_wdata = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [24:0] s_data = '0;
  logic [24:0] mac_a;
  logic [9:0]  mac_b;
  logic        mac_en;
  logic        mac_clr;
  logic [24:0] mac_result;
  logic        y_valid;
  logic [24:0] y_data;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [24:0] exp_q [$];
  logic [24:0] dat_q [$];
  int          acc_q [$];
  bit          bp_mode = 1'b0;
  int          bp_prev = -1;
  logic [24:0] acc;

  fir_mac_sequencer #(.NTAPS(8), .A_W(25), .B_W(10)) dut (
    .clk        (clk),
    .clr        (clr),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .mac_a      (mac_a),
    .mac_b      (mac_b),
    .mac_en     (mac_en),
    .mac_clr    (mac_clr),
    .mac_result (mac_result),
    .y_valid    (y_valid),
    .y_data     (y_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural MAC: p = (a * |b|) >> 9, added or subtracted by sign of b, mod 2^25.
  function automatic logic [24:0] mac_step(input logic [24:0] s, input logic [24:0] a, input logic [9:0] b);
    logic [9:0]  mag;
    logic [34:0] p;
    mag = b[9] ? (~b + 10'd1) : b;
    p   = ({10'd0, a} * {25'd0, mag}) >> 9;
    return b[9] ? (s - p[24:0]) : (s + p[24:0]);
  endfunction

  always @(posedge clk) begin
    if (mac_clr)     acc <= '0;
    else if (mac_en) acc <= mac_step(acc, mac_a, mac_b);
  end
  assign mac_result = acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Accept monitor: records the handshake cycle and checks the consumed data.
  always @(posedge clk) begin
    if (!clr && s_valid && s_ready) begin
      acc_q.push_back(cyc);
      if (dat_q.size() == 0) fail("unexpected_accept");
      else chk("accept_data", s_data, dat_q.pop_front());
      if (bp_mode) begin
        if (bp_prev >= 0) chk("accept_spacing", cyc - bp_prev, 12);
        bp_prev = cyc;
      end
    end
  end

  // Output monitor: pops expected results and accept times on each strobe.
  always @(negedge clk) begin
    if (!clr) chk("s_ready_vs_busy", s_ready, !busy);
    if (y_valid) begin
      if (exp_q.size() == 0) fail("unexpected_y_valid");
      else chk("y_data", y_data, exp_q.pop_front());
      if (acc_q.size() == 0) fail("y_without_accept");
      else chk("latency", cyc - acc_q.pop_front(), 11);
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy) fail("idle_timeout");
  endtask

  task automatic wcoef(input int a, input logic [9:0] v);
    wait_idle();
    coef_we    = 1'b1;
    coef_addr  = 3'(a);
    coef_wdata = v;
    @(negedge clk);
    coef_we    = 1'b0;
  endtask

  // Presents a sample and returns on the falling edge after it is accepted,
  // leaving s_valid high so the caller can hold it or drop it.
  task automatic send(input logic [24:0] d, input logic [24:0] e, input bit has_e);
    int n = 0;
    if (has_e) exp_q.push_back(e);
    dat_q.push_back(d);
    s_valid = 1'b1;
    s_data  = d;
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      fail("accept_timeout");
      s_valid = 1'b0;
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_y_valid"}, y_valid, 0);
    chk({tag, "_busy"},    busy,    0);
    chk({tag, "_s_ready"}, s_ready, 0);
    chk({tag, "_mac_en"},  mac_en,  0);
    chk({tag, "_mac_a"},   mac_a,   0);
    chk({tag, "_mac_b"},   mac_b,   0);
    chk({tag, "_mac_clr"}, mac_clr, 1);
    chk({tag, "_y_data"},  y_data,  0);
  endtask

  task automatic pulse_reset();
    wait_idle();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    acc_q.delete();
  endtask

  initial begin
    int n;
    #1 clr = 1'b1;
    #1 chk_reset_vals("por");
    repeat (2) @(negedge clk);
    clr = 1'b0;
    #1;
    chk("por_s_ready_release", s_ready, 1);
    chk("por_mac_clr_release", mac_clr, 0);

    // Impulse response
    wcoef(0, 10'd256);
    wcoef(1, 10'd128);
    wcoef(2, 10'd64);
    send(25'd1024, 25'd512, 1); s_valid = 1'b0;
    send(25'd0, 25'd256, 1);    s_valid = 1'b0;
    send(25'd0, 25'd128, 1);    s_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(25'd0, 25'd0, 1);
      s_valid = 1'b0;
    end

    // Negative coefficients, including -512
    wcoef(0, 10'h300);
    wcoef(1, 10'd0);
    wcoef(2, 10'd0);
    send(25'd1024, 25'h1FFFE00, 1); s_valid = 1'b0;
    wcoef(0, 10'h200);
    send(25'd1024, 25'h1FFFC00, 1); s_valid = 1'b0;

    // Truncation
    wcoef(0, 10'd511);
    send(25'd1, 25'd0, 1); s_valid = 1'b0;

    // Wrap: p = (2^25-1)*511 >> 9 = 2^25 - 65537, so k taps give 2^25 - 65537*k
    pulse_reset();
    for (int k = 0; k < 8; k++) wcoef(k, 10'd511);
    bp_prev = -1;
    bp_mode = 1'b1;
    for (int k = 1; k <= 8; k++) send(25'h1FFFFFF, 25'(33554432 - 65537 * k), 1);
    s_valid = 1'b0;
    bp_mode = 1'b0;

    // Backpressure with changing data: y = x >> 1
    wcoef(0, 10'd256);
    for (int k = 1; k < 8; k++) wcoef(k, 10'd0);
    bp_prev = -1;
    bp_mode = 1'b1;
    send(25'd100, 25'd50, 1);
    send(25'd202, 25'd101, 1);
    send(25'd300, 25'd150, 1);
    send(25'd4002, 25'd2001, 1);
    s_valid = 1'b0;
    bp_mode = 1'b0;

    // Write while busy is ignored; the same write in IDLE lands
    send(25'd1024, 25'd512, 1); s_valid = 1'b0;
    repeat (2) @(negedge clk);
    coef_we = 1'b1; coef_addr = 3'd0; coef_wdata = 10'd100;
    @(negedge clk);
    coef_we = 1'b0;
    wcoef(0, 10'd100);
    send(25'd1024, 25'd200, 1); s_valid = 1'b0;

    // Reset in the middle of RUN: no result for the aborted sample
    wait_idle();
    send(25'd1024, 25'd0, 0); s_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 clr = 1'b1;
    acc_q.delete();
    #1 chk_reset_vals("mid");
    @(negedge clk);
    @(negedge clk);
    clr = 1'b0;
    #1 chk("mid_s_ready_release", s_ready, 1);

    // Coefficient write and accept on the same edge
    coef_we = 1'b1; coef_addr = 3'd0; coef_wdata = 10'd256;
    send(25'd1024, 25'd512, 1);
    coef_we = 1'b0;
    s_valid = 1'b0;

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) fail("drain_timeout");
    repeat (15) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

endmodule
